cdc_chunker: RTL

CDC_CHUNKER -- requirements
Module: cdc_chunker

---
 rtl/cdc_chunker_pkg.sv | 29 ++
 rtl/cdc_chunker_gear_hash.sv | 32 +++
 rtl/cdc_chunker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_chunker_pkg.sv
// cdc_pkg: shared defaults, FSM state type and GEAR table for the chunker.
// Used by cdc_chunker (macro CDC_CHUNKER_HASH_OUT_EN) and cdc_gear_hash.
package cdc_pkg;

    localparam int DW_DEF     = 64;
    localparam int LEN_W_DEF  = 20;
    localparam int HASH_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // 256-entry GEAR table, generated by an integer mixer so the
    // constants need not be listed; the low HASH_W bits are used.
    function automatic logic [63:0] gear(input logic [7:0] b);
        logic [31:0] x;
        logic [31:0] y;
        x = {24'd0, b} * 32'h9E37_79B1 + 32'h7F4A_7C15;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA77;
        x = x ^ (x >> 13);
        y = x * 32'hC2B2_AE3D;
        y = y ^ (y >> 16);
        return {y, x};
    endfunction

endpackage

// File: rtl/cdc_chunker_gear_hash.sv
// cdc_gear_hash: one-byte gear-hash step, length step and cut decision.
// Purely combinational; the caller owns the hash and length registers.
module cdc_gear_hash
    import cdc_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int HASH_W = HASH_W_DEF
)(
    input  logic [HASH_W-1:0] i_hash,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [7:0]        i_byte,
    input  logic              i_eos,
    input  logic [LEN_W-1:0]  i_min,
    input  logic [LEN_W-1:0]  i_max,
    input  logic [HASH_W-1:0] i_mask,
    input  logic [HASH_W-1:0] i_magic,
    output logic [HASH_W-1:0] o_hash,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_cut
);

    logic w_hit;

    // Advance hash and length, then test content, max-length and end cuts.
    always_comb begin
        o_hash = (i_hash << 1) + HASH_W'(gear(i_byte));
        o_len  = i_len + LEN_W'(1);
        w_hit  = ((o_hash & i_mask) == i_magic) && (o_len >= i_min);
        o_cut  = w_hit || (o_len == i_max) || i_eos;
    end

endmodule

// File: rtl/cdc_chunker.sv
// cdc_chunker: content-defined chunker, one byte per clock, gear hash.
// Define CDC_CHUNKER_HASH_OUT_EN to drive out_hash; otherwise it reads 0.
module cdc_chunker
    import cdc_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int HASH_W = HASH_W_DEF
)(
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              enable,
    input  logic [LEN_W-1:0]  cfg_min,
    input  logic [LEN_W-1:0]  cfg_max,
    input  logic [HASH_W-1:0] cfg_mask,
    input  logic [HASH_W-1:0] cfg_magic,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [DW/8-1:0]   in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_off,
    output logic [LEN_W-1:0]  out_len,
    output logic [HASH_W-1:0] out_hash,
    output logic              out_last,
    output logic              busy
);

    localparam int NB = DW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    state_t            r_state;
    state_t            w_next;
    logic              w_idle;
    logic              w_run;
    logic              w_drain;

    logic [DW-1:0]     r_data;
    logic [NB-1:0]     r_keep;
    logic              r_last;
    logic              r_hv;
    logic [IW-1:0]     r_idx;

    logic [LEN_W-1:0]  r_len;
    logic [HASH_W-1:0] r_hash;
    logic [31:0]       r_off;

    logic [LEN_W-1:0]  r_min;
    logic [LEN_W-1:0]  r_max;
    logic [HASH_W-1:0] r_mask;
    logic [HASH_W-1:0] r_magic;

    logic              r_ov;
    logic [31:0]       r_ooff;
    logic [LEN_W-1:0]  r_olen;
    logic              r_olast;

    logic [7:0]        w_byte;
    logic              w_fin;
    logic              w_eos;
    logic [HASH_W-1:0] w_hash_n;
    logic [LEN_W-1:0]  w_len_n;
    logic              w_cut;
    logic              w_stall;
    logic              w_fire;
    logic              w_take;
    logic              w_start;
    logic              w_done;

    assign w_byte  = 8'(r_data >> {r_idx, 3'b000});
    assign w_fin   = ~|((r_keep >> r_idx) >> 1);
    assign w_eos   = r_last & w_fin;

    // A cut that cannot be delivered yet holds the current byte in place.
    assign w_stall = r_ov & ~out_ready & w_cut;
    assign w_fire  = w_run & r_hv & ~w_stall;

    // The last word of a stream blocks input until the stream has drained.
    assign in_ready = ~wb_rst_i & enable & ~w_drain &
                      (~r_hv | (w_fire & w_fin & ~r_last));
    assign w_take   = in_valid & in_ready;
    assign w_start  = w_idle & w_take;
    assign w_done   = w_drain & r_ov & out_ready;

    cdc_gear_hash #(
        .LEN_W  (LEN_W),
        .HASH_W (HASH_W)
    ) u_hash (
        .i_hash  (r_hash),
        .i_len   (r_len),
        .i_byte  (w_byte),
        .i_eos   (w_eos),
        .i_min   (r_min),
        .i_max   (r_max),
        .i_mask  (r_mask),
        .i_magic (r_magic),
        .o_hash  (w_hash_n),
        .o_len   (w_len_n),
        .o_cut   (w_cut)
    );

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // FSM next state; dropping enable always returns to IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_take) w_next = ST_RUN;
            ST_RUN:   if (w_fire && w_eos) w_next = ST_DRAIN;
            ST_DRAIN: if (w_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (!enable) w_next = ST_IDLE;
    end

    // FSM decoded outputs.
    always_comb begin
        w_idle  = 1'b0;
        w_run   = 1'b0;
        w_drain = 1'b0;
        unique case (r_state)
            ST_IDLE:  w_idle  = 1'b1;
            ST_RUN:   w_run   = 1'b1;
            ST_DRAIN: w_drain = 1'b1;
            default:  w_idle  = 1'b1;
        endcase
        busy = ~w_idle;
    end

    // Configuration is latched once, as a stream starts.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_min   <= '0;
            r_max   <= '0;
            r_mask  <= '0;
            r_magic <= '0;
        end else if (enable && w_start) begin
            r_min   <= cfg_min;
            r_max   <= cfg_max;
            r_mask  <= cfg_mask;
            r_magic <= cfg_magic;
        end
    end

    // Holding register: load on accept, walk kept bytes, empty after last.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_data <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
            r_hv   <= 1'b0;
            r_idx  <= '0;
        end else if (!enable) begin
            r_keep <= '0;
            r_last <= 1'b0;
            r_hv   <= 1'b0;
            r_idx  <= '0;
        end else if (w_take) begin
            r_data <= in_data;
            r_keep <= in_keep;
            r_last <= in_last;
            r_hv   <= 1'b1;
            r_idx  <= '0;
        end else if (w_fire) begin
            if (w_fin) r_hv <= 1'b0;
            else       r_idx <= r_idx + IW'(1);
        end
    end

    // Running chunk length, hash and start offset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_len  <= '0;
            r_hash <= '0;
            r_off  <= '0;
        end else if (!enable || w_done) begin
            r_len  <= '0;
            r_hash <= '0;
            r_off  <= '0;
        end else if (w_fire) begin
            if (w_cut) begin
                r_len  <= '0;
                r_hash <= '0;
                r_off  <= r_off + 32'(w_len_n);
            end else begin
                r_len  <= w_len_n;
                r_hash <= w_hash_n;
            end
        end
    end

    // Descriptor register: load on cut, clear on accept, else hold.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ov    <= 1'b0;
            r_ooff  <= '0;
            r_olen  <= '0;
            r_olast <= 1'b0;
        end else if (!enable) begin
            r_ov    <= 1'b0;
        end else if (w_fire && w_cut) begin
            r_ov    <= 1'b1;
            r_ooff  <= r_off;
            r_olen  <= w_len_n;
            r_olast <= w_eos;
        end else if (out_ready) begin
            r_ov    <= 1'b0;
        end
    end

`ifdef CDC_CHUNKER_HASH_OUT_EN
    logic [HASH_W-1:0] r_ohash;

    // Hash of the chunk just cut, aligned with the descriptor.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                       r_ohash <= '0;
        else if (enable && w_fire && w_cut) r_ohash <= w_hash_n;
    end

    assign out_hash = r_ohash;
`else
    assign out_hash = '0;
`endif

    assign out_valid = r_ov;
    assign out_off   = r_ooff;
    assign out_len   = r_olen;
    assign out_last  = r_olast;

endmodule
